// File: rtl/slc3_mem_arbiter_pkg.sv
// Shared types and default sizes for the SLC-3 SRAM arbiter.
//  state_e : access sequencer states (IDLE, SETUP, ACCESS, DONE)
//  owner_e : which requester holds (or last held) the SRAM port
//  DEF_*   : default address/data widths and strobe length
package slc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_e;

    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/slc3_mem_arbiter_if.sv
// Requester-side memory handshake bundle. The CPU and the program loader
// each own one instance.
//  req   : access request, level, held until done
//  we    : 1 = write, 0 = read
//  addr  : word address
//  wdata : write data
//  rdata : read data returned by the arbiter, held until the next read
//  done  : single-cycle completion pulse
// Modports: master = requester, slave = arbiter.
interface slc3_mem_arbiter_if
    import slc3_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              done;

    modport master (
        output req, we, addr, wdata,
        input  rdata, done
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, done
    );

endinterface

// File: rtl/slc3_mem_arbiter_arb.sv
// mem_rr_arb2: two-input round-robin grant.
//  clk, rst_n : clock and synchronous active-low reset
//  req[1:0]   : bit 0 = CPU, bit 1 = loader
//  update     : when high and a request is present, the winner becomes
//               the last-served side
//  grant[1:0] : one-hot winner (combinational), zero when no request
// After reset the loader counts as last served, so the CPU wins the first tie.
module mem_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    // On a tie, whichever side was not served last wins.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (update && (req != 2'b00)) begin
            last_d = grant[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/slc3_mem_arbiter.sv
// slc3_mem_arbiter: shares the single SRAM port between the SLC-3 CPU and
// the program loader. A granted access runs SETUP (address/data presented,
// strobes high), ACCESS (OE or WE low for WAIT_CYCLES cycles) and DONE
// (strobes high, done pulse to the owner), then returns to IDLE.
// Ports:
//  Clk, Reset      : clock, synchronous active-low reset
//  cpu, ldr        : requester handshakes (slc3_mem_arbiter_if.slave)
//  ADDR            : SRAM address, holds its last value while idle
//  Data_to_SRAM    : SRAM write data, zero while idle and during reads
//  Data_from_SRAM  : SRAM read data
//  OE, WE          : active-low SRAM strobes, never low together
//  busy            : high whenever an access is in progress
//  owner           : 0 = CPU, 1 = loader; current or last grant
//  wait_cnt        : contention counter
// Build option MEM_ARB_PERF_EN: when defined, wait_cnt counts cycles in which
// one side requests while the other side owns a busy port (saturating);
// otherwise wait_cnt is tied to zero.
// All outputs come straight from flops.
module slc3_mem_arbiter
    import slc3_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                Clk,
    input  logic                Reset,
    slc3_mem_arbiter_if.slave   cpu,
    slc3_mem_arbiter_if.slave   ldr,
    output logic [ADDR_W-1:0]   ADDR,
    output logic [DATA_W-1:0]   Data_to_SRAM,
    input  logic [DATA_W-1:0]   Data_from_SRAM,
    output logic                OE,
    output logic                WE,
    output logic                busy,
    output logic                owner,
    output logic [15:0]         wait_cnt
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    if (WAIT_CYCLES < 1) begin : g_wait_check
        $error("slc3_mem_arbiter: WAIT_CYCLES must be at least 1");
    end

    state_e            state_q,     state_d;
    owner_e            owner_q,     owner_d;
    logic              is_write_q,  is_write_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] dout_q,      dout_d;
    logic              oe_n_q,      oe_n_d;
    logic              we_n_q,      we_n_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
    logic              cpu_done_q,  cpu_done_d;
    logic              ldr_done_q,  ldr_done_d;
    logic              busy_q,      busy_d;

    logic [1:0]        grant;
    logic              arb_update;

    // Last-served only moves when a grant is actually taken in IDLE.
    assign arb_update = (state_q == IDLE);

    mem_rr_arb2 u_arb (
        .clk    (Clk),
        .rst_n  (Reset),
        .req    ({ldr.req, cpu.req}),
        .update (arb_update),
        .grant  (grant)
    );

    // Next-state and next-output logic. Strobes and done default to inactive
    // so only the cycle that needs them asserts them; the request fields are
    // copied only at grant, so later changes on the requester side are ignored.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        is_write_d  = is_write_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        cpu_done_d  = 1'b0;
        ldr_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant[1]) begin
                    state_d    = SETUP;
                    owner_d    = OWN_LDR;
                    is_write_d = ldr.we;
                    addr_d     = ldr.addr;
                    dout_d     = ldr.we ? ldr.wdata : '0;
                end else if (grant[0]) begin
                    state_d    = SETUP;
                    owner_d    = OWN_CPU;
                    is_write_d = cpu.we;
                    addr_d     = cpu.addr;
                    dout_d     = cpu.we ? cpu.wdata : '0;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = CNT_LOAD;
                oe_n_d  = is_write_q;
                we_n_d  = !is_write_q;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    // Read data is sampled while OE is still low in the
                    // final strobe cycle.
                    state_d = DONE;
                    if (owner_q == OWN_LDR) begin
                        ldr_done_d = 1'b1;
                        if (!is_write_q) ldr_rdata_d = Data_from_SRAM;
                    end else begin
                        cpu_done_d = 1'b1;
                        if (!is_write_q) cpu_rdata_d = Data_from_SRAM;
                    end
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    oe_n_d = is_write_q;
                    we_n_d = !is_write_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                dout_d  = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Synchronous reset aborts any access on the spot: strobes go high and
    // no done pulse or read data is produced.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            is_write_q  <= 1'b0;
            addr_q      <= '0;
            dout_q      <= '0;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            ldr_done_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            is_write_q  <= is_write_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
            cpu_done_q  <= cpu_done_d;
            ldr_done_q  <= ldr_done_d;
            busy_q      <= busy_d;
        end
    end

    assign ADDR         = addr_q;
    assign Data_to_SRAM = dout_q;
    assign OE           = oe_n_q;
    assign WE           = we_n_q;
    assign busy         = busy_q;
    assign owner        = owner_q;
    assign cpu.rdata    = cpu_rdata_q;
    assign cpu.done     = cpu_done_q;
    assign ldr.rdata    = ldr_rdata_q;
    assign ldr.done     = ldr_done_q;

`ifdef MEM_ARB_PERF_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        contend;

    // A side is waiting when it requests while the other side owns the port.
    always_comb begin
        contend    = busy_q && (((owner_q == OWN_CPU) && ldr.req) ||
                                ((owner_q == OWN_LDR) && cpu.req));
        wait_cnt_d = wait_cnt_q;
        if (contend && (wait_cnt_q != 16'hFFFF)) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            wait_cnt_q <= 16'h0000;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign wait_cnt = wait_cnt_q;
`else
    assign wait_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Directed testbench for slc3_mem_arbiter. A second instance with
// WAIT_CYCLES=1 covers the short-strobe configuration.
module tb_slc3_mem_arbiter;

    logic        Clk;
    logic        Reset;
    logic [15:0] ADDR, Data_to_SRAM, Data_from_SRAM, wait_cnt;
    logic        OE, WE, busy, owner;

    logic [15:0] w1_ADDR, w1_Data_to_SRAM, w1_Data_from_SRAM, w1_wait_cnt;
    logic        w1_OE, w1_WE, w1_busy, w1_owner;

    logic [15:0] wr_addr, wr_data;

    int compared;
    int mismatched;

`ifdef MEM_ARB_PERF_EN
    localparam logic [15:0] EXP_WAIT_7  = 16'd5;
    localparam logic [15:0] EXP_WAIT_20 = 16'd15;
`else
    localparam logic [15:0] EXP_WAIT_7  = 16'd0;
    localparam logic [15:0] EXP_WAIT_20 = 16'd0;
`endif

    slc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) cpu_if ();
    slc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) ldr_if ();
    slc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) w1_cpu_if ();
    slc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) w1_ldr_if ();

    slc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .cpu            (cpu_if),
        .ldr            (ldr_if),
        .ADDR           (ADDR),
        .Data_to_SRAM   (Data_to_SRAM),
        .Data_from_SRAM (Data_from_SRAM),
        .OE             (OE),
        .WE             (WE),
        .busy           (busy),
        .owner          (owner),
        .wait_cnt       (wait_cnt)
    );

    slc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) dut_w1 (
        .Clk            (Clk),
        .Reset          (Reset),
        .cpu            (w1_cpu_if),
        .ldr            (w1_ldr_if),
        .ADDR           (w1_ADDR),
        .Data_to_SRAM   (w1_Data_to_SRAM),
        .Data_from_SRAM (w1_Data_from_SRAM),
        .OE             (w1_OE),
        .WE             (w1_WE),
        .busy           (w1_busy),
        .owner          (w1_owner),
        .wait_cnt       (w1_wait_cnt)
    );

    // SRAM contents seen by both instances; junk is returned while OE is high.
    function automatic logic [15:0] rd_word(input logic [15:0] a);
        case (a)
            16'h3000: return 16'hBEEF;
            16'h0010: return 16'hAAAA;
            16'h0020: return 16'h5555;
            default:  return 16'h0000;
        endcase
    endfunction

    assign Data_from_SRAM    = OE    ? 16'hDEAD : rd_word(ADDR);
    assign w1_Data_from_SRAM = w1_OE ? 16'hDEAD : rd_word(w1_ADDR);

    // Record the last word strobed into the SRAM.
    always @(posedge Clk) begin
        if (!WE) begin
            wr_addr <= ADDR;
            wr_data <= Data_to_SRAM;
        end
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not reach the end in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (3) tick();
        compared++; if (OE !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_oe: got %b expected 1", OE); end
        compared++; if (WE !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_we: got %b expected 1", WE); end
        compared++; if (ADDR !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_addr: got %h expected 0000", ADDR); end
        compared++; if (Data_to_SRAM !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_dout: got %h expected 0000", Data_to_SRAM); end
        compared++; if (cpu_if.rdata !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_cpu_rdata: got %h expected 0000", cpu_if.rdata); end
        compared++; if (ldr_if.rdata !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_ldr_rdata: got %h expected 0000", ldr_if.rdata); end
        compared++; if ({cpu_if.done, ldr_if.done} !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 00", {cpu_if.done, ldr_if.done}); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        compared++; if (owner !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_owner: got %b expected 0", owner); end
        compared++; if (wait_cnt !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_wait_cnt: got %h expected 0000", wait_cnt); end
        Reset = 1'b1;
    endtask

    task automatic test_read();
        logic exp_oe;
        tick();
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 16'h3000; cpu_if.wdata = 16'h7777;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_oe = !((k == 2) || (k == 3));
            compared++; if (OE !== exp_oe) begin mismatched++; $display("[TB] FAIL read_oe cycle %0d: got %b expected %b", k, OE, exp_oe); end
            compared++; if (WE !== 1'b1) begin mismatched++; $display("[TB] FAIL read_we cycle %0d: got %b expected 1", k, WE); end
            compared++; if (cpu_if.done !== (k == 4)) begin mismatched++; $display("[TB] FAIL read_cpu_done cycle %0d: got %b expected %b", k, cpu_if.done, (k == 4)); end
            compared++; if (ldr_if.done !== 1'b0) begin mismatched++; $display("[TB] FAIL read_ldr_done cycle %0d: got %b expected 0", k, ldr_if.done); end
            compared++; if (busy !== (k <= 4)) begin mismatched++; $display("[TB] FAIL read_busy cycle %0d: got %b expected %b", k, busy, (k <= 4)); end
            compared++; if (Data_to_SRAM !== 16'h0000) begin mismatched++; $display("[TB] FAIL read_dout cycle %0d: got %h expected 0000", k, Data_to_SRAM); end
            if (k == 1) begin
                compared++; if (ADDR !== 16'h3000) begin mismatched++; $display("[TB] FAIL read_addr: got %h expected 3000", ADDR); end
                compared++; if (owner !== 1'b0) begin mismatched++; $display("[TB] FAIL read_owner: got %b expected 0", owner); end
            end
            if (k == 4) begin
                compared++; if (cpu_if.rdata !== 16'hBEEF) begin mismatched++; $display("[TB] FAIL read_rdata: got %h expected BEEF", cpu_if.rdata); end
                cpu_if.req = 1'b0;
            end
        end
    endtask

    task automatic test_write();
        int we_low;
        int oe_low;
        we_low = 0;
        oe_low = 0;
        tick();
        ldr_if.req = 1'b1; ldr_if.we = 1'b1; ldr_if.addr = 16'h0040; ldr_if.wdata = 16'h1234;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (!WE) we_low++;
            if (!OE) oe_low++;
            compared++; if (!OE && !WE) begin mismatched++; $display("[TB] FAIL write_strobes cycle %0d: got OE=%b WE=%b expected not both 0", k, OE, WE); end
            compared++; if (ADDR !== 16'h0040) begin mismatched++; $display("[TB] FAIL write_addr cycle %0d: got %h expected 0040", k, ADDR); end
            compared++; if (Data_to_SRAM !== ((k <= 4) ? 16'h1234 : 16'h0000)) begin mismatched++; $display("[TB] FAIL write_dout cycle %0d: got %h expected %h", k, Data_to_SRAM, ((k <= 4) ? 16'h1234 : 16'h0000)); end
            compared++; if (ldr_if.done !== (k == 4)) begin mismatched++; $display("[TB] FAIL write_ldr_done cycle %0d: got %b expected %b", k, ldr_if.done, (k == 4)); end
            compared++; if (cpu_if.done !== 1'b0) begin mismatched++; $display("[TB] FAIL write_cpu_done cycle %0d: got %b expected 0", k, cpu_if.done); end
            if (k == 1) begin
                compared++; if (owner !== 1'b1) begin mismatched++; $display("[TB] FAIL write_owner: got %b expected 1", owner); end
            end
            if (k == 4) ldr_if.req = 1'b0;
        end
        compared++; if (we_low != 2) begin mismatched++; $display("[TB] FAIL write_we_low_cycles: got %0d expected 2", we_low); end
        compared++; if (oe_low != 0) begin mismatched++; $display("[TB] FAIL write_oe_low_cycles: got %0d expected 0", oe_low); end
        compared++; if ({wr_addr, wr_data} !== {16'h0040, 16'h1234}) begin mismatched++; $display("[TB] FAIL write_sram_word: got %h/%h expected 0040/1234", wr_addr, wr_data); end
        compared++; if (ldr_if.rdata !== 16'h0000) begin mismatched++; $display("[TB] FAIL write_ldr_rdata: got %h expected 0000", ldr_if.rdata); end
    endtask

    task automatic test_back_to_back();
        logic exp_owner;
        tick();
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 16'h0010;
        ldr_if.req = 1'b1; ldr_if.we = 1'b0; ldr_if.addr = 16'h0020;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_owner = (((k - 1) / 5) % 2) == 1;
            compared++; if (owner !== exp_owner) begin mismatched++; $display("[TB] FAIL b2b_owner cycle %0d: got %b expected %b", k, owner, exp_owner); end
            compared++; if (busy !== ((k % 5) != 0)) begin mismatched++; $display("[TB] FAIL b2b_busy cycle %0d: got %b expected %b", k, busy, ((k % 5) != 0)); end
            compared++; if (cpu_if.done !== ((k == 4) || (k == 14))) begin mismatched++; $display("[TB] FAIL b2b_cpu_done cycle %0d: got %b expected %b", k, cpu_if.done, ((k == 4) || (k == 14))); end
            compared++; if (ldr_if.done !== ((k == 9) || (k == 19))) begin mismatched++; $display("[TB] FAIL b2b_ldr_done cycle %0d: got %b expected %b", k, ldr_if.done, ((k == 9) || (k == 19))); end
            if (k == 3) begin
                compared++; if (cpu_if.rdata !== 16'hBEEF) begin mismatched++; $display("[TB] FAIL b2b_cpu_rdata_hold: got %h expected BEEF", cpu_if.rdata); end
            end
            if (k == 4) begin
                compared++; if (cpu_if.rdata !== 16'hAAAA) begin mismatched++; $display("[TB] FAIL b2b_cpu_rdata: got %h expected AAAA", cpu_if.rdata); end
                compared++; if (ldr_if.rdata !== 16'h0000) begin mismatched++; $display("[TB] FAIL b2b_ldr_rdata_untouched: got %h expected 0000", ldr_if.rdata); end
            end
            if (k == 7) begin
                compared++; if (wait_cnt !== EXP_WAIT_7) begin mismatched++; $display("[TB] FAIL b2b_wait_cnt_7: got %0d expected %0d", wait_cnt, EXP_WAIT_7); end
            end
            if (k == 9) begin
                compared++; if (ldr_if.rdata !== 16'h5555) begin mismatched++; $display("[TB] FAIL b2b_ldr_rdata: got %h expected 5555", ldr_if.rdata); end
                compared++; if (cpu_if.rdata !== 16'hAAAA) begin mismatched++; $display("[TB] FAIL b2b_cpu_rdata_kept: got %h expected AAAA", cpu_if.rdata); end
            end
            if (k == 19) begin
                cpu_if.req = 1'b0;
                ldr_if.req = 1'b0;
            end
            if (k == 20) begin
                compared++; if (wait_cnt !== EXP_WAIT_20) begin mismatched++; $display("[TB] FAIL b2b_wait_cnt_20: got %0d expected %0d", wait_cnt, EXP_WAIT_20); end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        tick();
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 16'h3000;
        repeat (3) tick();
        compared++; if (OE !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_oe_before: got %b expected 0", OE); end
        Reset = 1'b0;
        cpu_if.req = 1'b0;
        tick();
        compared++; if ({OE, WE} !== 2'b11) begin mismatched++; $display("[TB] FAIL rstmid_strobes: got %b expected 11", {OE, WE}); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
        compared++; if (cpu_if.done !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_done: got %b expected 0", cpu_if.done); end
        compared++; if (cpu_if.rdata !== 16'h0000) begin mismatched++; $display("[TB] FAIL rstmid_rdata: got %h expected 0000", cpu_if.rdata); end
        compared++; if (wait_cnt !== 16'h0000) begin mismatched++; $display("[TB] FAIL rstmid_wait_cnt: got %h expected 0000", wait_cnt); end
        Reset = 1'b1;
        for (int k = 5; k <= 8; k++) begin
            tick();
            compared++; if ({cpu_if.done, busy} !== 2'b00) begin mismatched++; $display("[TB] FAIL rstmid_idle cycle %0d: got done/busy %b expected 00", k, {cpu_if.done, busy}); end
        end
    endtask

    task automatic test_req_withdrawn();
        tick();
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 16'h0010;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) begin
                cpu_if.req  = 1'b0;
                cpu_if.addr = 16'h0020;
            end
            compared++; if (cpu_if.done !== (k == 4)) begin mismatched++; $display("[TB] FAIL withdraw_done cycle %0d: got %b expected %b", k, cpu_if.done, (k == 4)); end
            compared++; if (busy !== (k <= 4)) begin mismatched++; $display("[TB] FAIL withdraw_busy cycle %0d: got %b expected %b", k, busy, (k <= 4)); end
            compared++; if (ADDR !== 16'h0010) begin mismatched++; $display("[TB] FAIL withdraw_addr cycle %0d: got %h expected 0010", k, ADDR); end
            if (k == 4) begin
                compared++; if (cpu_if.rdata !== 16'hAAAA) begin mismatched++; $display("[TB] FAIL withdraw_rdata: got %h expected AAAA", cpu_if.rdata); end
            end
        end
    endtask

    task automatic test_wait_one();
        tick();
        w1_cpu_if.req = 1'b1; w1_cpu_if.we = 1'b0; w1_cpu_if.addr = 16'h3000;
        for (int k = 1; k <= 4; k++) begin
            tick();
            compared++; if (w1_OE !== (k != 2)) begin mismatched++; $display("[TB] FAIL w1_oe cycle %0d: got %b expected %b", k, w1_OE, (k != 2)); end
            compared++; if (w1_cpu_if.done !== (k == 3)) begin mismatched++; $display("[TB] FAIL w1_done cycle %0d: got %b expected %b", k, w1_cpu_if.done, (k == 3)); end
            if (k == 3) begin
                compared++; if (w1_cpu_if.rdata !== 16'hBEEF) begin mismatched++; $display("[TB] FAIL w1_rdata: got %h expected BEEF", w1_cpu_if.rdata); end
                w1_cpu_if.req = 1'b0;
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        Reset = 1'b0;
        cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = 16'h0; cpu_if.wdata = 16'h0;
        ldr_if.req = 1'b0; ldr_if.we = 1'b0; ldr_if.addr = 16'h0; ldr_if.wdata = 16'h0;
        w1_cpu_if.req = 1'b0; w1_cpu_if.we = 1'b0; w1_cpu_if.addr = 16'h0; w1_cpu_if.wdata = 16'h0;
        w1_ldr_if.req = 1'b0; w1_ldr_if.we = 1'b0; w1_ldr_if.addr = 16'h0; w1_ldr_if.wdata = 16'h0;

        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_reset_mid_access();
        test_req_withdrawn();
        test_wait_one();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
